// File: rtl/vmicro16_apb_core_arbiter.sv
// ---------------------------------------------------------------------------
// vmicro16_apb_core_arbiter
//
// Round-robin arbiter that lets CORES core-side APB masters share one APB
// slave port. The winning request is registered in IDLE, then replayed
// downstream as a full SETUP/ACCESS sequence. Read data and the ready strobe
// go back only to the granted core. An optional access timeout forces
// completion (with ERR_DATA) so a stuck slave cannot hold the bus forever.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   S_PADDR/PWRITE/   per-core request lanes (lane i at [i*W +: W])
//   PSELx/PENABLE/PWDATA
//   S_PRDATA/PREADY   per-core response lanes (only granted lane is active)
//   M_*               single APB master port toward the peripheral section
//   grant             index of current / last granted core
//   busy              high while a downstream transfer is in flight
//   timeout_err       one-cycle pulse when an access is forced to complete
// ---------------------------------------------------------------------------
module vmicro16_apb_core_arbiter #(
  parameter int BUS_WIDTH      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CORES          = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CORES*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [CORES-1:0]            S_PWRITE,
  input  logic [CORES-1:0]            S_PSELx,
  input  logic [CORES-1:0]            S_PENABLE,
  input  logic [CORES*DATA_WIDTH-1:0] S_PWDATA,
  output logic [CORES*DATA_WIDTH-1:0] S_PRDATA,
  output logic [CORES-1:0]            S_PREADY,
  output logic [BUS_WIDTH-1:0]        M_PADDR,
  output logic                        M_PWRITE,
  output logic                        M_PSELx,
  output logic                        M_PENABLE,
  output logic [DATA_WIDTH-1:0]       M_PWDATA,
  input  logic [DATA_WIDTH-1:0]       M_PRDATA,
  input  logic                        M_PREADY,
  output logic [3:0]                  grant,
  output logic                        busy,
  output logic                        timeout_err
);

  // Counter only ever holds 0..TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             rr_ptr_reg, rr_ptr_next;
  logic [3:0]             grant_reg, grant_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BUS_WIDTH-1:0]   paddr_reg, paddr_next;
  logic                   pwrite_reg, pwrite_next;
  logic [DATA_WIDTH-1:0]  pwdata_reg, pwdata_next;

  logic                   xfer_done;
  logic                   xfer_timeout;
  logic [3:0]             winner;
  logic                   any_req;
  logic [DATA_WIDTH-1:0]  rsp_data;

  // Core lanes padded out to 16 entries so a 4-bit index always fits exactly.
  logic [15:0]            req_pad;
  logic [15:0]            pwrite_pad;
  logic [BUS_WIDTH-1:0]   lane_addr  [16];
  logic [DATA_WIDTH-1:0]  lane_wdata [16];

  // Phases are generated locally, so the cores' PENABLE carries no information.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  assign req_pad    = 16'(S_PSELx);
  assign pwrite_pad = 16'(S_PWRITE);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_lane_in
      if (gi < CORES) begin : g_real
        assign lane_addr[gi]  = S_PADDR[gi*BUS_WIDTH +: BUS_WIDTH];
        assign lane_wdata[gi] = S_PWDATA[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
        assign lane_addr[gi]  = '0;
        assign lane_wdata[gi] = '0;
      end
    end
  endgenerate

  // Round-robin search: first requester at or after rr_ptr, wrapping at CORES.
  always_comb begin
    logic [4:0] idx;
    logic       found;
    winner = rr_ptr_reg;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < CORES; k++) begin
      idx = {1'b0, rr_ptr_reg} + 5'(k);
      if (idx >= 5'(CORES)) idx = idx - 5'(CORES);
      if (!found && req_pad[idx[3:0]]) begin
        winner = idx[3:0];
        found  = 1'b1;
      end
    end
  end

  assign any_req = |S_PSELx;

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    grant_next   = grant_reg;
    cnt_next     = cnt_reg;
    paddr_next   = paddr_reg;
    pwrite_next  = pwrite_reg;
    pwdata_next  = pwdata_reg;
    xfer_done    = 1'b0;
    xfer_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (any_req) begin
          grant_next  = winner;
          paddr_next  = lane_addr[winner];
          pwrite_next = pwrite_pad[winner];
          pwdata_next = lane_wdata[winner];
          state_next  = SETUP;
        end
      end
      SETUP: begin
        cnt_next   = '0;
        state_next = ACCESS;
      end
      ACCESS: begin
        // A ready slave always wins over a timeout landing in the same cycle.
        if (M_PREADY) begin
          xfer_done = 1'b1;
        end else if (TIMEOUT_CYCLES != 0 &&
                     cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          xfer_done    = 1'b1;
          xfer_timeout = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
        if (xfer_done) begin
          state_next  = IDLE;
          rr_ptr_next = (grant_reg == 4'(CORES - 1)) ? 4'd0 : grant_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      cnt_reg    <= '0;
      paddr_reg  <= '0;
      pwrite_reg <= 1'b0;
      pwdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      cnt_reg    <= cnt_next;
      paddr_reg  <= paddr_next;
      pwrite_reg <= pwrite_next;
      pwdata_reg <= pwdata_next;
    end
  end

  assign M_PADDR     = paddr_reg;
  assign M_PWRITE    = pwrite_reg;
  assign M_PWDATA    = pwdata_reg;
  assign M_PSELx     = (state_reg != IDLE);
  assign M_PENABLE   = (state_reg == ACCESS);
  assign busy        = (state_reg != IDLE);
  assign grant       = grant_reg;
  // Responses are suppressed while reset is held so an aborted access
  // never reports completion.
  assign timeout_err = xfer_timeout && !reset;
  assign rsp_data    = xfer_timeout ? ERR_DATA : M_PRDATA;

  generate
    for (genvar gi = 0; gi < CORES; gi++) begin : g_lane_out
      logic sel;
      assign sel = xfer_done && !reset && (grant_reg == 4'(gi));
      // A core that dropped its select mid-transfer gets no ready strobe.
      assign S_PREADY[gi] = sel && S_PSELx[gi];
      assign S_PRDATA[gi*DATA_WIDTH +: DATA_WIDTH] = sel ? rsp_data : '0;
    end
  endgenerate

endmodule

// File: tb/tb_vmicro16_apb_core_arbiter.sv
module tb_vmicro16_apb_core_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;
  localparam logic [DW-1:0] ERR = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N*AW-1:0] S_PADDR = '0;
  logic [N-1:0]    S_PWRITE = '0, S_PSELx = '0, S_PENABLE = '0;
  logic [N*DW-1:0] S_PWDATA = '0;
  logic [N*DW-1:0] S_PRDATA;
  logic [N-1:0]    S_PREADY;
  logic [AW-1:0]   M_PADDR;
  logic            M_PWRITE, M_PSELx, M_PENABLE;
  logic [DW-1:0]   M_PWDATA;
  logic [DW-1:0]   M_PRDATA = '0;
  logic            M_PREADY = 1'b0;
  logic [3:0]      grant;
  logic            busy, timeout_err;

  always #5 clk = ~clk;

  vmicro16_apb_core_arbiter #(
    .BUS_WIDTH(AW), .DATA_WIDTH(DW), .CORES(N), .TIMEOUT_CYCLES(T), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA),
    .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  // Core-side request model: what each core currently drives.
  logic [AW-1:0] c_addr  [N];
  logic          c_wr    [N];
  logic [DW-1:0] c_wdata [N];
  logic [N-1:0]  pend = '0;
  int            rr_ptr = 0;

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      S_PADDR[i*AW +: AW]  = c_addr[i];
      S_PWRITE[i]          = c_wr[i];
      S_PWDATA[i*DW +: DW] = c_wdata[i];
    end
    S_PSELx   = pend;
    S_PENABLE = 4'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    c_addr[i]  = $urandom;
    c_wr[i]    = 1'($urandom);
    c_wdata[i] = $urandom;
  endtask

  // Round-robin rule: first pending core at or after the pointer, wrapping.
  function automatic int pick_winner();
    for (int k = 0; k < N; k++)
      if (pend[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; pend = '0; M_PREADY = 1'b0; M_PRDATA = '0;
    drive(); step(); step();
    reset = 1'b0; rr_ptr = 0;
  endtask

  // Runs one arbitration slot starting in an IDLE cycle. The slave raises
  // PREADY on ACCESS cycle waits+1; the access times out on ACCESS cycle T.
  task automatic run_transfer(input int waits, input bit drop,
                              input logic [DW-1:0] rd, input int exp_g,
                              output int g);
    logic [AW-1:0] ea;
    logic          ew;
    logic [DW-1:0] ed;
    logic [N*DW-1:0] exp_prdata;
    logic [N-1:0]  exp_pready;
    bit fin, tmo, rdy;
    int k;
    g = (exp_g >= 0) ? exp_g : pick_winner();
    M_PREADY = 1'b0;
    drive();
    @(negedge clk);
    checks++;
    if ({busy, M_PSELx, M_PENABLE, timeout_err} !== 4'b0 || S_PREADY !== '0 || S_PRDATA !== '0) begin
      failures++;
      $display("FAIL idle: busy/psel/pen/terr=%b%b%b%b pready=%b prdata=%h, want all zero",
               busy, M_PSELx, M_PENABLE, timeout_err, S_PREADY, S_PRDATA);
    end
    if (g < 0) begin
      step();
      return;
    end
    ea = c_addr[g]; ew = c_wr[g]; ed = c_wdata[g];
    step();
    for (int i = 0; i < N; i++) c_wdata[i] = $urandom;
    drive();
    @(negedge clk);
    checks++;
    if ({busy, M_PSELx, M_PENABLE} !== 3'b110 || grant !== 4'(g)) begin
      failures++;
      $display("FAIL setup_phase: busy/psel/pen=%b%b%b grant=%0d, want 110 grant=%0d",
               busy, M_PSELx, M_PENABLE, grant, g);
    end
    checks++;
    if (M_PADDR !== ea || M_PWRITE !== ew || M_PWDATA !== ed) begin
      failures++;
      $display("FAIL setup_latch: addr=%h wr=%b wdata=%h, want addr=%h wr=%b wdata=%h",
               M_PADDR, M_PWRITE, M_PWDATA, ea, ew, ed);
    end
    step();
    fin = 1'b0; k = 0;
    while (!fin && k < 40) begin
      k++;
      rdy = (k == waits + 1);
      tmo = !rdy && (k == T);
      fin = rdy || tmo;
      if (drop && k == 1) pend[g] = 1'b0;
      for (int i = 0; i < N; i++) c_wdata[i] = $urandom;
      M_PREADY = rdy;
      M_PRDATA = rdy ? rd : $urandom;
      drive();
      @(negedge clk);
      exp_pready = '0;
      exp_prdata = '0;
      if (fin) begin
        if (!drop) exp_pready[g] = 1'b1;
        exp_prdata[g*DW +: DW] = rdy ? rd : ERR;
      end
      checks++;
      if ({M_PSELx, M_PENABLE, busy} !== 3'b111 || M_PADDR !== ea || M_PWDATA !== ed || M_PWRITE !== ew) begin
        failures++;
        $display("FAIL access_hold cyc=%0d: psel/pen/busy=%b%b%b addr=%h wdata=%h wr=%b, want 111 addr=%h wdata=%h wr=%b",
                 k, M_PSELx, M_PENABLE, busy, M_PADDR, M_PWDATA, M_PWRITE, ea, ed, ew);
      end
      checks++;
      if (S_PREADY !== exp_pready || S_PRDATA !== exp_prdata || timeout_err !== tmo) begin
        failures++;
        $display("FAIL response cyc=%0d: pready=%b prdata=%h terr=%b, want pready=%b prdata=%h terr=%b",
                 k, S_PREADY, S_PRDATA, timeout_err, exp_pready, exp_prdata, tmo);
      end
      step();
    end
    M_PREADY = 1'b0;
    pend[g] = 1'b0;
    rr_ptr = (g + 1) % N;
    $display("txn core=%0d addr=%h write=%0b access_cycles=%0d drop=%0b timeout=%0b",
             g, ea, ew, k, drop, tmo);
  endtask

  task automatic test_reset();
    int g;
    reset = 1'b1;
    for (int i = 0; i < N; i++) new_req(i);
    pend = 4'b1111;
    drive(); step(); step();
    @(negedge clk);
    checks++;
    if ({M_PSELx, M_PENABLE, busy, timeout_err, M_PWRITE} !== 5'b0 || M_PADDR !== '0 ||
        M_PWDATA !== '0 || grant !== 4'd0 || S_PREADY !== '0 || S_PRDATA !== '0) begin
      failures++;
      $display("FAIL reset_state: psel=%b pen=%b busy=%b terr=%b addr=%h wdata=%h grant=%0d pready=%b, want all zero",
               M_PSELx, M_PENABLE, busy, timeout_err, M_PADDR, M_PWDATA, grant, S_PREADY);
    end
    pend = '0; drive();
    step();
    reset = 1'b0; rr_ptr = 0;
    run_transfer(0, 1'b0, '0, -1, g);
  endtask

  task automatic test_single();
    int g;
    c_addr[0] = 32'h50; c_wr[0] = 1'b0; pend = 4'b0001;
    run_transfer(0, 1'b0, 32'h1234, 0, g);
  endtask

  task automatic test_contention();
    int g;
    apply_reset();
    new_req(1); new_req(3);
    pend = 4'b1010;
    run_transfer(int'($urandom_range(0, 3)), 1'b0, $urandom, 1, g);
    run_transfer(int'($urandom_range(0, 3)), 1'b0, $urandom, 3, g);
  endtask

  task automatic test_fairness();
    int g;
    apply_reset();
    for (int i = 0; i < N; i++) new_req(i);
    pend = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      run_transfer(0, 1'b0, $urandom, i % N, g);
      new_req(g);
      pend[g] = 1'b1;
    end
    pend = '0;
    run_transfer(0, 1'b0, '0, -1, g);
  endtask

  task automatic test_wait_states();
    int g;
    c_addr[2] = $urandom; c_wr[2] = 1'b1; c_wdata[2] = 32'hA5;
    pend = 4'b0100;
    run_transfer(5, 1'b0, $urandom, 2, g);
  endtask

  task automatic test_timeout();
    int g;
    new_req(1); pend = 4'b0010;
    run_transfer(100, 1'b0, $urandom, 1, g);
    run_transfer(0, 1'b0, '0, -1, g);
    new_req(0); pend = 4'b0001;
    run_transfer(T - 1, 1'b0, $urandom, 0, g);
  endtask

  task automatic test_drop();
    int g;
    new_req(3); c_wr[3] = 1'b1; pend = 4'b1000;
    run_transfer(3, 1'b1, $urandom, 3, g);
  endtask

  task automatic test_reset_abort();
    int g;
    apply_reset();
    new_req(2); pend = 4'b0100;
    run_transfer(0, 1'b0, $urandom, 2, g);
    new_req(0); pend = 4'b0001;
    drive(); step(); step();
    M_PREADY = 1'b0; drive(); step();
    reset = 1'b1; M_PREADY = 1'b1; M_PRDATA = $urandom; drive();
    @(negedge clk);
    checks++;
    if (S_PREADY !== '0 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_ready: pready=%b terr=%b, want 0 0", S_PREADY, timeout_err);
    end
    step();
    reset = 1'b0; M_PREADY = 1'b0; pend = '0; drive();
    @(negedge clk);
    checks++;
    if ({M_PSELx, M_PENABLE, busy, M_PWRITE} !== 4'b0 || M_PADDR !== '0 || M_PWDATA !== '0 ||
        grant !== 4'd0 || S_PREADY !== '0 || S_PRDATA !== '0) begin
      failures++;
      $display("FAIL abort_state: psel=%b pen=%b busy=%b addr=%h grant=%0d pready=%b, want all zero",
               M_PSELx, M_PENABLE, busy, M_PADDR, grant, S_PREADY);
    end
    step();
    rr_ptr = 0;
    // Pointer was 3 before the abort; after reset it must be back at 0.
    new_req(0); new_req(3); pend = 4'b1001;
    run_transfer(1, 1'b0, $urandom, 0, g);
    run_transfer(1, 1'b0, $urandom, 3, g);
  endtask

  task automatic test_random();
    int g;
    apply_reset();
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          new_req(i);
          pend[i] = 1'b1;
        end
      run_transfer(int'($urandom_range(0, 10)), ($urandom_range(0, 7) == 0),
                   $urandom, -1, g);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      c_addr[i] = '0; c_wr[i] = 1'b0; c_wdata[i] = '0;
    end
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_wait_states();
    test_timeout();
    test_drop();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vmicro16_apb_core_arbiter.md
Name: vmicro16_apb_core_arbiter

Overview:
- Round-robin APB arbiter that shares the single APB slave port of the peripheral section between CORES core-side APB masters.
- Sits between the per-core APB master ports and the peripheral section's S_* input.
- Registers the winning master's request and drives a full SETUP/ACCESS sequence downstream.
- Returns PRDATA/PREADY only to the granted core.
- Bounds every access with a timeout so a hung slave cannot lock the bus.

Parameters:
- BUS_WIDTH, 32, address width per master.
- DATA_WIDTH, 32, data width per master.
- CORES, 4, number of requesting masters (1..16).
- TIMEOUT_CYCLES, 255, max ACCESS cycles before forced completion; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF, PRDATA returned on timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- S_PADDR  in  CORES*BUS_WIDTH  per-core address, lane i = [i*BUS_WIDTH +: BUS_WIDTH].
- S_PWRITE  in  CORES  per-core write flag.
- S_PSELx  in  CORES  per-core request/select.
- S_PENABLE  in  CORES  per-core enable; ignored (arbiter generates its own phases).
- S_PWDATA  in  CORES*DATA_WIDTH  per-core write data.
- S_PRDATA  out  CORES*DATA_WIDTH  per-core read data.
- S_PREADY  out  CORES  per-core completion strobe.
- M_PADDR  out  BUS_WIDTH  to peripheral section.
- M_PWRITE  out  1  to peripheral section.
- M_PSELx  out  1  to peripheral section.
- M_PENABLE  out  1  to peripheral section.
- M_PWDATA  out  DATA_WIDTH  to peripheral section.
- M_PRDATA  in  DATA_WIDTH  from peripheral section.
- M_PREADY  in  1  from peripheral section.
- grant  out  4  index of current/last granted core.
- busy  out  1  high in SETUP or ACCESS.
- timeout_err  out  1  one-cycle pulse on forced completion.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- States: IDLE, SETUP, ACCESS.
- Reset values: state=IDLE, rr_ptr=0, grant=0, timeout counter=0. All M_* outputs 0. S_PREADY=0, S_PRDATA=0, busy=0, timeout_err=0.
- IDLE, no S_PSELx bit set: stay in IDLE.
- IDLE, any S_PSELx bit set:
  - Winner g = first set bit searching from rr_ptr upward, wrapping at CORES-1 -> 0.
  - Register grant=g and latch M_PADDR, M_PWRITE, M_PWDATA from lane g.
  - Next state SETUP.
- SETUP: M_PSELx=1, M_PENABLE=0. Counter cleared. Unconditionally -> ACCESS.
- ACCESS: M_PSELx=1, M_PENABLE=1. Latched M_PADDR/M_PWRITE/M_PWDATA held stable; core-side changes are not forwarded.
- Completion: cycle in ACCESS with M_PREADY=1.
  - Combinationally, S_PREADY[g]=S_PSELx[g] and S_PRDATA lane g = M_PRDATA.
  - Next state IDLE; rr_ptr=(g+1) mod CORES.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter increments each ACCESS cycle with M_PREADY=0.
  - When the counter equals TIMEOUT_CYCLES-1 and M_PREADY=0: S_PREADY[g]=S_PSELx[g], S_PRDATA lane g=ERR_DATA, timeout_err=1 for that cycle.
  - Next state IDLE, rr_ptr advances, M_PSELx/M_PENABLE drop next cycle.
- Simultaneous M_PREADY and timeout in the same cycle: normal completion wins; no timeout_err.
- Non-granted lanes: S_PREADY=0 and S_PRDATA=0 at all times. Granted lane PRDATA=0 outside its completion cycle.
- Latency: an uncontended zero-wait access completes 3 cycles after S_PSELx is sampled (IDLE, SETUP, ACCESS). Minimum 3 cycles per transfer; a pending request is granted in the IDLE cycle immediately after completion.
- Granted core drops S_PSELx mid-transfer: the downstream transfer still runs to completion or timeout (writes take effect); no S_PREADY is issued.
- Reset mid-transfer: immediate return to reset values; no S_PREADY issued; rr_ptr=0.
- CORES=1: rr_ptr stays 0; behaves as a registering APB bridge.
- grant and busy: busy=1 in SETUP/ACCESS. grant holds its value in IDLE until the next grant.

Test Plan:
- Single access: core 0 requests a read of 0x50, slave returns 0x1234 with 0 wait states -> M_PSELx rises 1 cycle after the request, M_PENABLE 1 cycle later; S_PREADY[0]=1 and S_PRDATA lane 0=0x1234 in the same cycle; other lanes 0.
- Contention: cores 1 and 3 request together with rr_ptr=0 -> core 1 served first, then core 3. Core 3's request stays pending with no S_PREADY until its own completion.
- Fairness: all 4 cores request continuously for 8 transfers -> grant order 0,1,2,3,0,1,2,3; every transfer is 3 cycles.
- Wait states: slave holds M_PREADY low for 5 ACCESS cycles on a write of 0xA5 -> M_PADDR/M_PWDATA stay stable throughout; the core changing S_PWDATA mid-access has no effect; single S_PREADY pulse.
- Timeout: TIMEOUT_CYCLES=8, slave never ready -> after 8 ACCESS cycles, S_PREADY[g]=1, PRDATA=0xDEADBEEF, timeout_err pulses once, bus returns to IDLE.
- Reset/abort: assert reset during ACCESS -> next cycle all outputs 0, state IDLE, no S_PREADY. Separately, the granted core drops S_PSELx mid-ACCESS -> the slave sees the full transfer and no S_PREADY is issued.
